// File: rtl/aes_uart_frame_loader.sv
// aes_uart_frame_loader
//   Receives a 33-byte command frame over UART (8N1, LSB first) and hands it
//   to the AES core: header (0xA5 encrypt / 0x5A decrypt), 16 key bytes,
//   16 data bytes. The key, data and mode are presented as registered values,
//   and a one-cycle start pulse is issued once the core reports ready.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   rx            UART serial input (idle high)
//   core_ready    AES core idle; gates the start pulse
//   err_clr       one-cycle pulse clearing err_flags
//   aes_start     one-cycle start pulse to the core
//   enc_dec_out   1 = encrypt, 0 = decrypt
//   key_out       128-bit key; first received key byte in [127:120]
//   data_out      128-bit data block, same byte order as key_out
//   busy          frame in progress or waiting on core_ready
//   byte_cnt      bytes accepted in the current frame (0..33)
//   err_flags     sticky: [3] overrun, [2] timeout, [1] header, [0] framing
module aes_uart_frame_loader #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx,
    input  logic         core_ready,
    input  logic         err_clr,
    output logic         aes_start,
    output logic         enc_dec_out,
    output logic [127:0] key_out,
    output logic [127:0] data_out,
    output logic         busy,
    output logic [5:0]   byte_cnt,
    output logic [3:0]   err_flags
);
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int CW       = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {HDR, KEY, DATA, LOAD, WAIT_RDY} fr_state_t;

    // ---------------- RX bit engine ----------------
    logic          rx_s1, rx_s2, rx_d;
    rx_state_t     rx_state, rx_nx;
    logic [CW-1:0] bit_tmr;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic          tick, start_evt, byte_valid, frame_err;

    // rx_d is one more delay of the synchronized bit, used only for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign tick       = (bit_tmr == CW'(CPB - 1));
    assign start_evt  = (rx_state == RX_IDLE) && rx_d && !rx_s2;
    assign byte_valid = (rx_state == RX_STOP) && tick && rx_s2;
    assign frame_err  = (rx_state == RX_STOP) && tick && !rx_s2;

    always_comb begin
        rx_nx = rx_state;
        case (rx_state)
            RX_IDLE:  if (start_evt) rx_nx = RX_START;
            // mid-start-bit recheck: line back high means it was a glitch
            RX_START: if (bit_tmr == CW'(HALF - 1)) rx_nx = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) rx_nx = RX_STOP;
            RX_STOP:  if (tick) rx_nx = RX_IDLE;
            default:  rx_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            bit_tmr  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_nx;
            if (rx_state == RX_IDLE || rx_nx != rx_state || tick)
                bit_tmr <= '0;
            else
                bit_tmr <= bit_tmr + 1'b1;
            if (rx_state == RX_START) begin
                bit_idx <= '0;
            end else if (rx_state == RX_DATA && tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                bit_idx  <= bit_idx + 1'b1;
            end
        end
    end

    // ---------------- frame FSM ----------------
    fr_state_t     state, state_nx;
    logic [5:0]    byte_cnt_nx;
    logic [127:0]  key_sh, data_sh;
    logic          mode_pend;
    logic [TW-1:0] to_cnt;
    logic          in_frame, timeout, shift_key, shift_data, do_load, start_nx;
    logic [3:0]    err_set;

    assign in_frame = (state == KEY) || (state == DATA);
    assign timeout  = in_frame && !byte_valid && !start_evt && (to_cnt == TW'(TO_LIMIT - 1));
    assign busy     = (state != HDR);

    always_comb begin
        state_nx    = state;
        byte_cnt_nx = byte_cnt;
        shift_key   = 1'b0;
        shift_data  = 1'b0;
        do_load     = 1'b0;
        start_nx    = 1'b0;
        err_set     = {1'b0, timeout, 1'b0, frame_err};
        case (state)
            HDR: begin
                if (byte_valid) begin
                    if (rx_shift == 8'hA5 || rx_shift == 8'h5A) begin
                        state_nx    = KEY;
                        byte_cnt_nx = 6'd1;
                    end else begin
                        err_set[1] = 1'b1;
                    end
                end
            end
            KEY, DATA: begin
                if (frame_err || timeout) begin
                    state_nx    = HDR;
                    byte_cnt_nx = 6'd0;
                end else if (byte_valid) begin
                    byte_cnt_nx = byte_cnt + 6'd1;
                    if (state == KEY) begin
                        shift_key = 1'b1;
                        if (byte_cnt == 6'd16) state_nx = DATA;
                    end else begin
                        shift_data = 1'b1;
                        if (byte_cnt == 6'd32) state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                do_load    = 1'b1;
                err_set[3] = byte_valid;
                state_nx   = WAIT_RDY;
            end
            WAIT_RDY: begin
                err_set[3] = byte_valid;
                if (core_ready) begin
                    start_nx    = 1'b1;
                    byte_cnt_nx = 6'd0;
                    state_nx    = HDR;
                end
            end
            default: state_nx = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HDR;
            byte_cnt    <= '0;
            aes_start   <= 1'b0;
            key_sh      <= '0;
            data_sh     <= '0;
            mode_pend   <= 1'b1;
            key_out     <= '0;
            data_out    <= '0;
            enc_dec_out <= 1'b1;
            err_flags   <= '0;
            to_cnt      <= '0;
        end else begin
            state     <= state_nx;
            byte_cnt  <= byte_cnt_nx;
            // registered so outputs loaded in LOAD are stable a cycle before start
            aes_start <= start_nx;
            if (state == HDR && state_nx == KEY) mode_pend <= (rx_shift == 8'hA5);
            if (shift_key)  key_sh  <= {key_sh[119:0], rx_shift};
            if (shift_data) data_sh <= {data_sh[119:0], rx_shift};
            if (do_load) begin
                key_out     <= key_sh;
                data_out    <= data_sh;
                enc_dec_out <= mode_pend;
            end
            // a new error in the same cycle as err_clr survives the clear
            err_flags <= (err_clr ? 4'b0000 : err_flags) | err_set;
            if (!in_frame || byte_valid || start_evt)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end
endmodule

// File: doc/aes_uart_frame_loader.md
Name: aes_uart_frame_loader

Overview:
Upstream feeder for the AES core. It receives a 33-byte command frame over UART RX: a header byte selecting the mode, then 16 key bytes, then 16 data bytes. When the frame is complete it presents the key, data and mode to the core as stable registered values and issues a single-cycle start pulse once the core reports ready. It replaces the switch-selected test vectors with host-supplied vectors, and its error and progress outputs drive status LEDs.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 868 at defaults).
TIMEOUT_BITS, 20, maximum inter-byte gap in bit periods while a frame is in progress.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
rx  in  1  UART serial input; idle high, 8N1, LSB first
core_ready  in  1  AES core ready/idle
err_clr  in  1  single-cycle pulse; clears err_flags
aes_start  out  1  single-cycle start pulse to the core
enc_dec_out  out  1  1 = encrypt, 0 = decrypt
key_out  out  128  key to the core
data_out  out  128  plaintext or ciphertext to the core
busy  out  1  high while a frame is in progress or waiting on core_ready
byte_cnt  out  6  bytes accepted in the current frame (0..33)
err_flags  out  4  sticky errors: [3] overrun, [2] timeout, [1] header, [0] framing

Behaviour:
- Reset values: all outputs 0 except enc_dec_out = 1. The synchronizer flops and all internal shift registers reset to 0, except the synchronizer, which resets to 1 (idle).
- rx passes through a 2-FF synchronizer. All RX logic uses the synchronized bit.
- RX bit engine:
  - Start is a high-to-low transition of the synchronized rx.
  - Re-check the line at CLKS_PER_BIT/2. If it is high, treat the event as a glitch and return to idle with no error.
  - Sample the 8 data bits at CLKS_PER_BIT intervals, LSB first, then the stop bit.
  - At the stop-bit sample, raise internal byte_valid for 1 cycle. A stop bit of 0 sets err_flags[0], aborts the frame, and does not raise byte_valid.
- Frame FSM states: HDR, KEY, DATA, LOAD, WAIT_RDY.
  - HDR: 0xA5 sets pending mode to encrypt and 0x5A to decrypt; go to KEY with byte_cnt = 1. Any other byte sets err_flags[1]; stay in HDR with byte_cnt = 0.
  - KEY: bytes 1..16 shift into the key shadow register. The first key byte ends up in bits [127:120]. After byte 16, go to DATA.
  - DATA: bytes 17..32 go to the data shadow register, ordered the same way. The byte_valid of byte 32 (byte_cnt reaches 33) moves to LOAD.
  - LOAD (1 cycle): copy the shadows and pending mode into key_out, data_out and enc_dec_out. These outputs change only here. Go to WAIT_RDY.
  - WAIT_RDY: on the first cycle with core_ready = 1, assert aes_start for exactly 1 cycle, clear byte_cnt, and go to HDR. Consequence: aes_start is no earlier than 2 cycles after the last byte_valid, and the outputs are stable at least 1 cycle before start.
- busy = 1 in KEY, DATA, LOAD and WAIT_RDY.
- Inter-byte timeout (KEY and DATA only):
  - Count cycles from each byte_valid; reset the count on each new start edge.
  - If the count reaches TIMEOUT_BITS*CLKS_PER_BIT, set err_flags[2], clear byte_cnt and go to HDR.
- Abort (framing error or timeout): partial shadow contents are discarded, and key_out, data_out and enc_dec_out keep their previous values.
- A byte_valid while in WAIT_RDY or LOAD sets err_flags[3]. The byte is dropped and the state is unaffected.
- err_flags are sticky and OR-accumulate. err_clr clears them. If err_clr and a new error occur in the same cycle, the new error wins and the flag reads 1.
- Reset asserted mid-frame or mid-byte: immediate return to the reset state. The next frame needs a fresh start edge and header.

Test Plan:
- Encrypt frame: A5, key 000102…0e0f, data 00112233…eeff, with core_ready = 1. Required: key_out/data_out match exactly, enc_dec_out = 1, aes_start is exactly 1 cycle wide, it occurs 2 cycles after the last stop-bit sample, byte_cnt returns to 0, err_flags = 0.
- Decrypt frame with core_ready held low: 5A, key 2b7e1516…4f3c, data 3925841d…0b32. Required: outputs latched and enc_dec_out = 0, no aes_start while core_ready = 0; aes_start on the first cycle core_ready rises; an extra byte sent during the wait sets err_flags = 4'b1000 and leaves the outputs unchanged.
- Bad header 0x33 followed by a valid A5 frame. Required: err_flags[1] = 1, byte_cnt stays 0 after 0x33, the following frame completes normally, and err_clr returns err_flags to 0.
- Stop bit forced to 0 on key byte 5. Required: err_flags[0] = 1, state returns to HDR, byte_cnt = 0, no aes_start, key_out unchanged from the previous frame.
- Line idles 25 bit periods after data byte 20. Required: err_flags[2] set once the idle reaches 20 bit periods (20*868 cycles), byte_cnt = 0, no aes_start; a subsequent full frame succeeds.
- rx low pulse of 300 cycles (shorter than half a bit period, 434 cycles). Required: no byte accepted, no error flag. Separately, rst_n asserted during DATA byte 25: all outputs return to reset values immediately.
